maxicore32_core: RTL and testbench

- Minimal 32-bit multi-cycle load/store CPU core.
- Fetches 32-bit instructions over a single word-addressed bus into a synchronous RAM with one-cycle read latency.
- Executes ALU, load/store and branch instructions using a program counter and 16×32 register file (r0–r15, all general purpose).
- Reports illegal/finished execution on `halted` and misaligned accesses on `bus_error`.

---
 rtl/maxicore32_core.sv | 226 ++++++++++++++++++++++
 tb/tb_maxicore32_core.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxicore32_core.sv
// maxicore32_core: multi-cycle 32-bit load/store CPU core.
// Define MAXICORE32_MULTIPLY_EN to enable the MUL (0F) and MULI (17) opcodes.
module maxicore32_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [29:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic [3:0]  data_strobes,
    output logic        read,
    output logic        write,
    output logic        bus_error,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2,
        LOADWB  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] program_counter;
    logic [31:0] register_file [16];
    logic [31:0] ir_q;
    logic        z_q, n_q, c_q;
    logic        halted_q, bus_error_q;
    logic [1:0]  lane_q;

    logic [5:0]  op;
    logic [3:0]  rd, ra, rb;
    logic [31:0] simm, a_val, b_val, rd_val, ea;
    logic        is_alu, is_load, is_store, is_branch;
    logic        is_loadi, is_loadup, legal, do_halt;
    logic        misalign, load_go, store_go, taken, frozen;
    logic [31:0] alu_b, alu_r, st_data, ld_val;
    logic        alu_c;
    logic [3:0]  st_strb;

    assign op     = ir_q[31:26];
    assign rd     = ir_q[25:22];
    assign ra     = ir_q[21:18];
    assign rb     = ir_q[17:14];
    assign simm   = {{16{ir_q[15]}}, ir_q[15:0]};
    assign a_val  = register_file[ra];
    assign b_val  = register_file[rb];
    assign rd_val = register_file[rd];
    assign ea     = a_val + simm;
    assign frozen = halted_q | bus_error_q;

    assign halted    = halted_q;
    assign bus_error = bus_error_q;

`ifdef MAXICORE32_MULTIPLY_EN
    assign is_alu = (op[5:3] == 3'b001) || (op[5:3] == 3'b010);
`else
    assign is_alu = ((op[5:3] == 3'b001) || (op[5:3] == 3'b010))
                  && (op[2:0] != 3'd7);
`endif
    assign is_loadi  = (op == 6'h02);
    assign is_loadup = (op == 6'h03);
    assign is_load   = (op == 6'h20) || (op == 6'h21) || (op == 6'h22);
    assign is_store  = (op == 6'h24) || (op == 6'h25) || (op == 6'h26);
    assign is_branch = (op[5:3] == 3'b110) && (op[2:0] <= 3'd4);

    // HALT (01) is deliberately absent so it falls into do_halt with illegals
    assign legal = (op == 6'h00) || is_loadi || is_loadup || is_alu
                || is_load || is_store || is_branch;
    assign do_halt = ~legal;

    assign misalign = (is_load || is_store)
                   && (((op[1:0] == 2'd0) && (ea[1:0] != 2'b00))
                    || ((op[1:0] == 2'd1) && ea[0]));
    assign load_go  = is_load & ~misalign;
    assign store_go = is_store & ~misalign;

    always_comb begin
        alu_b = op[4] ? simm : b_val;
        alu_c = 1'b0;
        alu_r = '0;
        unique case (op[2:0])
            3'd0: {alu_c, alu_r} = {1'b0, a_val} + {1'b0, alu_b};
            3'd1: begin
                alu_r = a_val - alu_b;
                alu_c = (a_val < alu_b);
            end
            3'd2: alu_r = a_val & alu_b;
            3'd3: alu_r = a_val | alu_b;
            3'd4: alu_r = a_val ^ alu_b;
            3'd5: alu_r = a_val << alu_b[4:0];
            3'd6: alu_r = a_val >> alu_b[4:0];
`ifdef MAXICORE32_MULTIPLY_EN
            3'd7: alu_r = a_val * alu_b;
`else
            3'd7: alu_r = '0;
`endif
        endcase
    end

    always_comb begin
        unique case (op[2:0])
            3'd0:    taken = 1'b1;
            3'd1:    taken = z_q;
            3'd2:    taken = ~z_q;
            3'd3:    taken = n_q;
            3'd4:    taken = c_q;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        st_data = rd_val;
        st_strb = 4'b1111;
        if (op[1:0] == 2'd1) begin
            st_data = {2{rd_val[15:0]}};
            st_strb = ea[1] ? 4'b0011 : 4'b1100;
        end else if (op[1:0] == 2'd2) begin
            st_data = {4{rd_val[7:0]}};
            st_strb = 4'b1000 >> ea[1:0];
        end
    end

    // Big-endian lanes: offset 0 lives in bits 31:24
    always_comb begin
        unique case (op[1:0])
            2'd1:    ld_val = (data_in >> {~lane_q[1], 4'b0000}) & 32'h0000_FFFF;
            2'd2:    ld_val = (data_in >> {~lane_q, 3'b000}) & 32'h0000_00FF;
            default: ld_val = data_in;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!frozen) begin
            case (state_q)
                FETCH:   state_d = DECODE;
                DECODE:  state_d = EXECUTE;
                EXECUTE: state_d = load_go ? LOADWB : FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    always_comb begin
        read         = 1'b0;
        write        = 1'b0;
        address      = program_counter[31:2];
        data_strobes = 4'b0000;
        data_out     = '0;
        if (reset && !frozen) begin
            case (state_q)
                FETCH: begin
                    read         = 1'b1;
                    data_strobes = 4'b1111;
                end
                EXECUTE: begin
                    if (load_go) begin
                        read         = 1'b1;
                        address      = ea[31:2];
                        data_strobes = 4'b1111;
                    end
                    if (store_go) begin
                        write        = 1'b1;
                        address      = ea[31:2];
                        data_strobes = st_strb;
                        data_out     = st_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            program_counter <= RESET_PC;
            for (int i = 0; i < 16; i++) register_file[i] <= '0;
            ir_q        <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            halted_q    <= 1'b0;
            bus_error_q <= 1'b0;
            lane_q      <= '0;
        end else if (!frozen) begin
            case (state_q)
                DECODE: begin
                    ir_q            <= data_in;
                    program_counter <= program_counter + 32'd4;
                end
                EXECUTE: begin
                    unique case (1'b1)
                        do_halt:   halted_q <= 1'b1;
                        misalign:  bus_error_q <= 1'b1;
                        is_loadi:  register_file[rd] <= simm;
                        is_loadup: register_file[rd] <= {ir_q[15:0], rd_val[15:0]};
                        is_alu: begin
                            register_file[rd] <= alu_r;
                            z_q <= (alu_r == 32'd0);
                            n_q <= alu_r[31];
                            c_q <= alu_c;
                        end
                        load_go:   lane_q <= ea[1:0];
                        is_branch: begin
                            if (taken)
                                program_counter <= program_counter
                                                 + {simm[29:0], 2'b00};
                        end
                        default: ;
                    endcase
                end
                LOADWB: register_file[rd] <= ld_val;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maxicore32_core.sv
// Testbench for maxicore32_core: directed programs plus random programs
// checked against an instruction-level reference interpreter.
module tb_maxicore32_core;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [29:0] address;
    logic [31:0] data_in, data_out;
    logic [3:0]  data_strobes;
    logic        read, write, bus_error, halted;

    always #5 clock = ~clock;

    maxicore32_core #(.RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset), .address(address),
        .data_in(data_in), .data_out(data_out),
        .data_strobes(data_strobes), .read(read), .write(write),
        .bus_error(bus_error), .halted(halted)
    );

    logic [31:0] mem [256];
    logic [31:0] rdata = '0;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [29:0] last_rd_addr = '0;
    logic [3:0]  last_rd_strb = '0;
    logic [3:0]  last_drd_strb = '0;
    logic [3:0]  last_wr_strb = '0;
    logic [31:0] last_wr_data = '0;

    assign data_in = rdata;

    // Memory with one-cycle read latency plus a bus monitor
    always @(posedge clock) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (write) begin
            for (int l = 0; l < 4; l++)
                if (data_strobes[l])
                    mem[address[7:0]][8*l +: 8] <= data_out[8*l +: 8];
        end
        if (read) begin
            rdata        <= mem[address[7:0]];
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= address;
            last_rd_strb <= data_strobes;
            if (address >= 30'd16) last_drd_strb <= data_strobes;
        end
        if (write) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_strb <= data_strobes;
            last_wr_data <= data_out;
        end
    end

    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] img [256];
    logic [31:0] mm [256];
    logic [31:0] mrf [16];
    logic [31:0] mpc;
    logic        mz, mn, mc, mhalt, mberr;
    int          mcyc;
    int          cyc;
    logic [31:0] prog [$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ri(input logic [5:0] op,
        input logic [3:0] rd, input logic [3:0] ra, input logic [15:0] imm);
        return {op, rd, ra, 2'b00, imm};
    endfunction

    function automatic logic [31:0] rr(input logic [5:0] op,
        input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb);
        return {op, rd, ra, rb, 14'd0};
    endfunction

    // Returns {carry, result}
    function automatic logic [32:0] alu(input logic [2:0] k,
        input logic [31:0] a, input logic [31:0] b);
        case (k)
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {(a < b), a - b};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, a << b[4:0]};
            3'd6: return {1'b0, a >> b[4:0]};
            default: return {1'b0, a * b};
        endcase
    endfunction

    task automatic model_run();
        logic [31:0] ir, a, b, rv, simm, ea, w;
        logic [5:0]  op;
        logic [3:0]  rd, ra, rb;
        logic [32:0] res;
        logic        alu_ok, cond, bad;
        int          sh;
        mpc = 32'h0;
        for (int i = 0; i < 16; i++) mrf[i] = '0;
        mz = 0; mn = 0; mc = 0; mhalt = 0; mberr = 0; mcyc = 0;
        for (int k = 0; k < 1000; k++) begin
            if (mhalt || mberr) break;
            ir = mm[mpc[9:2]];
            mpc = mpc + 32'd4;
            mcyc += 3;
            op = ir[31:26]; rd = ir[25:22]; ra = ir[21:18]; rb = ir[17:14];
            simm = {{16{ir[15]}}, ir[15:0]};
            a = mrf[ra]; rv = mrf[rd];
            b = (op >= 6'h10) ? simm : mrf[rb];
            ea = a + simm;
            alu_ok = (op >= 6'h08 && op <= 6'h0E) || (op >= 6'h10 && op <= 6'h16);
`ifdef MAXICORE32_MULTIPLY_EN
            alu_ok = alu_ok || op == 6'h0F || op == 6'h17;
`endif
            bad = ((op == 6'h20 || op == 6'h24) && ea[1:0] != 2'b00)
               || ((op == 6'h21 || op == 6'h25) && ea[0]);
            sh = 8 * (3 - int'(ea[1:0]));
            if (alu_ok) begin
                res = alu(op[2:0], a, b);
                mrf[rd] = res[31:0];
                mz = (res[31:0] == 0); mn = res[31]; mc = res[32];
            end else case (op)
                6'h00: ;
                6'h02: mrf[rd] = simm;
                6'h03: mrf[rd] = {ir[15:0], rv[15:0]};
                6'h20, 6'h21, 6'h22: begin
                    if (bad) mberr = 1;
                    else begin
                        w = mm[ea[9:2]];
                        mcyc += 1;
                        if (op == 6'h20) mrf[rd] = w;
                        else if (op == 6'h21)
                            mrf[rd] = ea[1] ? {16'h0, w[15:0]} : {16'h0, w[31:16]};
                        else mrf[rd] = {24'h0, w[sh +: 8]};
                    end
                end
                6'h24, 6'h25, 6'h26: begin
                    if (bad) mberr = 1;
                    else begin
                        w = mm[ea[9:2]];
                        if (op == 6'h24) w = rv;
                        else if (op == 6'h25) begin
                            if (ea[1]) w[15:0] = rv[15:0];
                            else w[31:16] = rv[15:0];
                        end else w[sh +: 8] = rv[7:0];
                        mm[ea[9:2]] = w;
                    end
                end
                6'h30, 6'h31, 6'h32, 6'h33, 6'h34: begin
                    cond = (op == 6'h30) || (op == 6'h31 && mz) || (op == 6'h32 && !mz)
                        || (op == 6'h33 && mn) || (op == 6'h34 && mc);
                    if (cond) mpc = mpc + (simm << 2);
                end
                default: mhalt = 1;
            endcase
        end
    endtask

    task automatic run_prog(input string tag);
        logic [31:0] acc;
        logic        done;
        int          diffs;
        for (int i = 0; i < 256; i++) img[i] = $urandom;
        foreach (prog[i]) img[i] = prog[i];
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            ld_en = 1'b1; ld_addr = 8'(i); ld_data = img[i];
        end
        @(negedge clock);
        ld_en = 1'b0;
        check({tag, ".rst_bus"}, {29'd0, read, write, |data_strobes}, 32'd0);
        check({tag, ".rst_flags"}, {30'd0, halted, bus_error}, 32'd0);
        check({tag, ".rst_pc"}, dut.program_counter, 32'h0);
        acc = '0;
        for (int i = 0; i < 16; i++) acc = acc | dut.register_file[i];
        check({tag, ".rst_regs"}, acc, 32'h0);
        for (int i = 0; i < 256; i++) mm[i] = img[i];
        model_run();
        reset = 1'b1;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 300) begin
            @(posedge clock);
            #1;
            cyc++;
            if (halted || bus_error) done = 1'b1;
        end
        check({tag, ".done"}, {31'd0, done}, 32'd1);
        check({tag, ".cycles"}, cyc, mcyc);
        check({tag, ".halted"}, {31'd0, halted}, {31'd0, mhalt});
        check({tag, ".bus_error"}, {31'd0, bus_error}, {31'd0, mberr});
        check({tag, ".pc"}, dut.program_counter, mpc);
        check({tag, ".flags"}, {29'd0, dut.z_q, dut.n_q, dut.c_q}, {29'd0, mz, mn, mc});
        for (int i = 0; i < 16; i++)
            check($sformatf("%s.r%0d", tag, i), dut.register_file[i], mrf[i]);
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== mm[i]) diffs++;
        check({tag, ".mem_diffs"}, diffs, 0);
    endtask

    initial begin
        int snap_rd, snap_wr;
        logic [31:0] snap_pc;

        prog = {ri(6'h01, 4'd0, 4'd0, 16'h0)};
        run_prog("halt");
        check("halt.cycles3", cyc, 3);
        check("halt.pc4", dut.program_counter, 32'h4);
        check("halt.fetch_addr", {2'b00, last_rd_addr}, 32'h0);
        check("halt.fetch_strb", {28'd0, last_rd_strb}, 32'hF);

        prog = {ri(6'h02, 4'd1, 4'd0, 16'd5), ri(6'h02, 4'd2, 4'd0, 16'hFFFD),
                rr(6'h08, 4'd3, 4'd1, 4'd2), ri(6'h01, 4'd0, 4'd0, 16'h0)};
        run_prog("add");
        check("add.r3", dut.register_file[3], 32'h2);
        check("add.zc", {30'd0, dut.z_q, dut.c_q}, 32'b01);

        prog = {ri(6'h02, 4'd1, 4'd0, 16'h40), ri(6'h02, 4'd2, 4'd0, 16'h1234),
                ri(6'h03, 4'd2, 4'd0, 16'hABCD), ri(6'h24, 4'd2, 4'd1, 16'h0),
                ri(6'h22, 4'd4, 4'd1, 16'h1), ri(6'h01, 4'd0, 4'd0, 16'h0)};
        run_prog("stw_ldb");
        check("stw_ldb.mem", mem[16], 32'hABCD1234);
        check("stw_ldb.r4", dut.register_file[4], 32'h000000CD);
        check("stw_ldb.wstrb", {28'd0, last_wr_strb}, 32'hF);
        check("stw_ldb.rstrb", {28'd0, last_drd_strb}, 32'hF);

        prog = {ri(6'h02, 4'd1, 4'd0, 16'h40), ri(6'h02, 4'd2, 4'd0, 16'hBEEF),
                ri(6'h03, 4'd2, 4'd0, 16'h0), ri(6'h25, 4'd2, 4'd1, 16'h2),
                ri(6'h20, 4'd3, 4'd1, 16'h0), ri(6'h01, 4'd0, 4'd0, 16'h0)};
        run_prog("sth");
        check("sth.wstrb", {28'd0, last_wr_strb}, 32'h3);
        check("sth.wdata", {16'd0, last_wr_data[15:0]}, 32'hBEEF);
        check("sth.r3lo", {16'd0, dut.register_file[3][15:0]}, 32'hBEEF);

        prog = {ri(6'h02, 4'd1, 4'd0, 16'h41), ri(6'h20, 4'd2, 4'd1, 16'h0),
                ri(6'h01, 4'd0, 4'd0, 16'h0)};
        run_prog("misal");
        check("misal.berr", {31'd0, bus_error}, 32'd1);
        check("misal.r2", dut.register_file[2], 32'h0);
        snap_rd = rd_cnt; snap_wr = wr_cnt; snap_pc = dut.program_counter;
        repeat (6) @(posedge clock);
        #1;
        check("misal.no_read", rd_cnt, snap_rd);
        check("misal.no_write", wr_cnt, snap_wr);
        check("misal.pc_frozen", dut.program_counter, snap_pc);

        prog = {ri(6'h02, 4'd1, 4'd0, 16'd3), ri(6'h11, 4'd1, 4'd1, 16'd1),
                ri(6'h32, 4'd0, 4'd0, 16'hFFFE), ri(6'h01, 4'd0, 4'd0, 16'h0)};
        run_prog("loop");
        check("loop.r1", dut.register_file[1], 32'h0);
        check("loop.halted", {31'd0, halted}, 32'd1);
        check("loop.cycles", cyc, 24);

        for (int t = 0; t < 8; t++) begin
            prog = {ri(6'h02, 4'd15, 4'd0, 16'h0200)};
            for (int r = 1; r < 7; r++)
                prog.push_back(ri(6'h02, 4'(r), 4'd0, 16'($urandom)));
            for (int i = 0; i < 14; i++) begin
                int sel;
                logic [15:0] off;
                sel = $urandom_range(0, 8);
                off = 16'($urandom_range(0, 15) * 4);
                if ($urandom_range(0, 5) == 0) off = off + 16'($urandom_range(1, 3));
                case (sel)
                    0: prog.push_back(ri(6'h02, 4'($urandom_range(0, 14)), 4'd0, 16'($urandom)));
                    1: prog.push_back(ri(6'h03, 4'($urandom_range(0, 14)), 4'd0, 16'($urandom)));
                    2, 3: prog.push_back(rr(6'(8 + $urandom_range(0, 7)), 4'($urandom_range(0, 14)),
                            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))));
                    4: prog.push_back(ri(6'(16 + $urandom_range(0, 7)), 4'($urandom_range(0, 14)),
                            4'($urandom_range(0, 15)), 16'($urandom)));
                    5: prog.push_back(ri(6'(36 + $urandom_range(0, 2)), 4'($urandom_range(0, 15)),
                            4'd15, off));
                    6: prog.push_back(ri(6'(32 + $urandom_range(0, 2)), 4'($urandom_range(0, 15)),
                            4'd15, off));
                    7: prog.push_back(ri(6'(48 + $urandom_range(0, 4)), 4'd0, 4'd0,
                            16'($urandom_range(0, 2))));
                    default: if ($urandom_range(0, 3) == 0)
                                prog.push_back(ri(6'h3F, 4'd0, 4'd0, 16'h0));
                             else prog.push_back(ri(6'h00, 4'd0, 4'd0, 16'h0));
                endcase
            end
            repeat (3) prog.push_back(ri(6'h01, 4'd0, 4'd0, 16'h0));
            run_prog($sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
